hc_pipelined_subtractor: RTL and testbench



---
 rtl/hc_pipelined_subtractor_pkg.sv | 23 ++
 rtl/hc_pipelined_subtractor_prefix_cell.sv | 24 ++
 rtl/hc_pipelined_subtractor.sv | 202 ++++++++++++++++++++
 tb/tb_hc_pipelined_subtractor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hc_pipelined_subtractor_pkg.sv
// Shared constants and stage payload type for the Han-Carlson pipelined subtractor.
// Optional feature macro used by the top: HC_SUB_OVF_EN (adds the signed-overflow output).
package hc_pipelined_subtractor_pkg;

  localparam int HC_WIDTH     = 18;
  localparam int HC_LEVELS    = 5;
  localparam int HC_S1_LEVELS = 3;

  // Bit j of every vector is prefix column j+1; column 0 is the borrow-in
  // column (generate = ~bin, propagate = 0) and is carried by the bin field.
  typedef struct packed {
    logic [HC_WIDTH-1:0] p;      // raw propagate, kept for the sum XOR
    logic [HC_WIDTH-1:0] g_grp;  // group generate after the levels done so far
    logic [HC_WIDTH-1:0] p_grp;  // group propagate after the levels done so far
    logic                bin;    // borrow-in of this beat
  } hc_stage_t;

  // Distance to the partner column at a given prefix level (1-based).
  function automatic int hc_span(input int lvl);
    return 1 << (lvl - 1);
  endfunction

endpackage

// File: rtl/hc_pipelined_subtractor_prefix_cell.sv
// Prefix operator cell: black (HAS_P=1) outputs group generate and propagate,
// grey (HAS_P=0) outputs group generate only and drives p_out low.
module hc_prefix_cell #(
  parameter bit HAS_P = 1'b1
) (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g_out,
  output logic p_out
);

  assign g_out = g_hi | (p_hi & g_lo);

  if (HAS_P) begin : g_black
    assign p_out = p_hi & p_lo;
  end else begin : g_grey
    logic unused_p_lo;
    assign unused_p_lo = p_lo;
    assign p_out       = 1'b0;
  end

endmodule

// File: rtl/hc_pipelined_subtractor.sv
// Three-stage 18-bit subtractor (a - b - bin) on a Han-Carlson borrow tree with
// valid/ready on both sides. S0 registers p/g, S1 registers prefix levels 1-3,
// S2 finishes levels 4-5, the even-column grey row and the sum.
// Macro HC_SUB_OVF_EN adds the pipelined signed-overflow output ovf.
module hc_pipelined_subtractor
  import hc_pipelined_subtractor_pkg::*;
#(
  parameter int WIDTH = HC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef HC_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int W = HC_WIDTH;

  hc_stage_t      s0_q, s0_d, s1_q, s1_d;
  logic           v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
  logic [W-1:0]   diff_q, diff_d;
  logic           bout_q, bout_d;
  logic           ld0, ld1, ld2;
  logic           cin0, cin1;
  logic [W-1:0]   l1_g, l1_p, l2_g, l2_p, l3_g, l3_p, l4_g, l4_p, l5_g;
  logic [W-1:0]   cf, carry;
`ifdef HC_SUB_OVF_EN
  logic           ovf_q, ovf_d;
`endif

  assign cin0 = ~s0_q.bin;
  assign cin1 = ~s1_q.bin;

  // Level 1 (span 1): odd columns combine with their even neighbour
  for (genvar j = 0; j < W; j++) begin : g_lvl1
    if (j % 2 == 1) begin : g_pass
      assign l1_g[j] = s0_q.g_grp[j];
      assign l1_p[j] = s0_q.p_grp[j];
    end else if (j < hc_span(1)) begin : g_cin
      hc_prefix_cell #(.HAS_P(1'b1)) u_cell (.g_hi(s0_q.g_grp[j]), .p_hi(s0_q.p_grp[j]),
        .g_lo(cin0), .p_lo(1'b0), .g_out(l1_g[j]), .p_out(l1_p[j]));
    end else begin : g_cell
      hc_prefix_cell #(.HAS_P(1'b1)) u_cell (.g_hi(s0_q.g_grp[j]), .p_hi(s0_q.p_grp[j]),
        .g_lo(s0_q.g_grp[j-hc_span(1)]), .p_lo(s0_q.p_grp[j-hc_span(1)]),
        .g_out(l1_g[j]), .p_out(l1_p[j]));
    end
  end

  // Levels 2..5 fold in the borrow-in column once the span reaches past it;
  // that group already contains column 0, so the extra merge is idempotent.
  for (genvar j = 0; j < W; j++) begin : g_lvl2
    if (j % 2 == 1) begin : g_pass
      assign l2_g[j] = l1_g[j];
      assign l2_p[j] = l1_p[j];
    end else if (j < hc_span(2)) begin : g_cin
      hc_prefix_cell #(.HAS_P(1'b1)) u_cell (.g_hi(l1_g[j]), .p_hi(l1_p[j]),
        .g_lo(cin0), .p_lo(1'b0), .g_out(l2_g[j]), .p_out(l2_p[j]));
    end else begin : g_cell
      hc_prefix_cell #(.HAS_P(1'b1)) u_cell (.g_hi(l1_g[j]), .p_hi(l1_p[j]),
        .g_lo(l1_g[j-hc_span(2)]), .p_lo(l1_p[j-hc_span(2)]), .g_out(l2_g[j]), .p_out(l2_p[j]));
    end
  end

  for (genvar j = 0; j < W; j++) begin : g_lvl3
    if (j % 2 == 1) begin : g_pass
      assign l3_g[j] = l2_g[j];
      assign l3_p[j] = l2_p[j];
    end else if (j < hc_span(HC_S1_LEVELS)) begin : g_cin
      hc_prefix_cell #(.HAS_P(1'b1)) u_cell (.g_hi(l2_g[j]), .p_hi(l2_p[j]),
        .g_lo(cin0), .p_lo(1'b0), .g_out(l3_g[j]), .p_out(l3_p[j]));
    end else begin : g_cell
      hc_prefix_cell #(.HAS_P(1'b1)) u_cell (.g_hi(l2_g[j]), .p_hi(l2_p[j]),
        .g_lo(l2_g[j-hc_span(HC_S1_LEVELS)]), .p_lo(l2_p[j-hc_span(HC_S1_LEVELS)]),
        .g_out(l3_g[j]), .p_out(l3_p[j]));
    end
  end

  for (genvar j = 0; j < W; j++) begin : g_lvl4
    if (j % 2 == 1) begin : g_pass
      assign l4_g[j] = s1_q.g_grp[j];
      assign l4_p[j] = s1_q.p_grp[j];
    end else if (j < hc_span(4)) begin : g_cin
      hc_prefix_cell #(.HAS_P(1'b1)) u_cell (.g_hi(s1_q.g_grp[j]), .p_hi(s1_q.p_grp[j]),
        .g_lo(cin1), .p_lo(1'b0), .g_out(l4_g[j]), .p_out(l4_p[j]));
    end else begin : g_cell
      hc_prefix_cell #(.HAS_P(1'b1)) u_cell (.g_hi(s1_q.g_grp[j]), .p_hi(s1_q.p_grp[j]),
        .g_lo(s1_q.g_grp[j-hc_span(4)]), .p_lo(s1_q.p_grp[j-hc_span(4)]),
        .g_out(l4_g[j]), .p_out(l4_p[j]));
    end
  end

  // Level 5 is the last odd-column level, so only generate is needed
  for (genvar j = 0; j < W; j++) begin : g_lvl5
    logic unused_p;
    if (j % 2 == 1) begin : g_pass
      assign l5_g[j] = l4_g[j];
      assign unused_p = 1'b0;
    end else if (j < hc_span(HC_LEVELS)) begin : g_cin
      hc_prefix_cell #(.HAS_P(1'b0)) u_cell (.g_hi(l4_g[j]), .p_hi(l4_p[j]),
        .g_lo(cin1), .p_lo(1'b0), .g_out(l5_g[j]), .p_out(unused_p));
    end else begin : g_cell
      hc_prefix_cell #(.HAS_P(1'b0)) u_cell (.g_hi(l4_g[j]), .p_hi(l4_p[j]),
        .g_lo(l4_g[j-hc_span(HC_LEVELS)]), .p_lo(l4_p[j-hc_span(HC_LEVELS)]),
        .g_out(l5_g[j]), .p_out(unused_p));
    end
  end

  // Final grey row: even columns take the completed prefix of their left neighbour
  for (genvar j = 0; j < W; j++) begin : g_fin
    logic unused_p;
    if (j % 2 == 0) begin : g_odd_col
      assign cf[j]    = l5_g[j];
      assign unused_p = 1'b0;
    end else begin : g_even_col
      hc_prefix_cell #(.HAS_P(1'b0)) u_cell (.g_hi(l5_g[j]), .p_hi(l4_p[j]),
        .g_lo(l5_g[j-1]), .p_lo(1'b0), .g_out(cf[j]), .p_out(unused_p));
    end
  end

  assign carry = {cf[W-2:0], cin1};

  // Ready chain: a stage may load when it is empty or the stage after it loads
  always_comb begin
    ld2      = ~v2_q | out_ready;
    ld1      = ~v1_q | ld2;
    ld0      = ~v0_q | ld1;
    in_ready = ld0;
    v0_d     = ld0 ? in_valid : v0_q;
    v1_d     = ld1 ? v0_q : v1_q;
    v2_d     = ld2 ? v1_q : v2_q;
  end

  // Stage payloads: capture only when a valid beat moves in
  always_comb begin
    s0_d   = s0_q;
    s1_d   = s1_q;
    diff_d = diff_q;
    bout_d = bout_q;
`ifdef HC_SUB_OVF_EN
    ovf_d  = ovf_q;
`endif
    if (ld0 && in_valid) begin
      s0_d = '{p: a ^ ~b, g_grp: a & ~b, p_grp: a ^ ~b, bin: bin};
    end
    if (ld1 && v0_q) begin
      s1_d = '{p: s0_q.p, g_grp: l3_g, p_grp: l3_p, bin: s0_q.bin};
    end
    if (ld2 && v1_q) begin
      diff_d = s1_q.p ^ carry;
      bout_d = ~cf[W-1];
`ifdef HC_SUB_OVF_EN
      // Top bit: p=0 means a and b differ there, and then g equals a's sign bit
      ovf_d  = ~s1_q.p[W-1] & (diff_d[W-1] ^ s1_q.g_grp[W-1]);
`endif
    end
  end

  // Pipeline registers, flushed by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      s0_q   <= '0;
      s1_q   <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
`ifdef HC_SUB_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      v0_q   <= v0_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      s0_q   <= s0_d;
      s1_q   <= s1_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
`ifdef HC_SUB_OVF_EN
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign out_valid = v2_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
`ifdef HC_SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_hc_pipelined_subtractor.sv
// Directed and randomised checks for hc_pipelined_subtractor.
module tb_hc_pipelined_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] a;
  logic [17:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] diff;
  logic        bout;
`ifdef HC_SUB_OVF_EN
  logic        ovf;
`endif

  int total = 0;
  int bad   = 0;

  logic [17:0] sa [5];
  logic [17:0] sb [5];
  logic        sbin [5];
  logic [18:0] sexp [5];
  logic [18:0] rq [$];

  hc_pipelined_subtractor dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
`ifdef HC_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat: fixed 3-stage latency, then the result for exactly one cycle
  task automatic run_one(input string tag, input logic [17:0] va, input logic [17:0] vb,
                         input logic vbin, input logic [17:0] ed, input logic eb, input logic eo);
    out_ready = 1'b1;
    a = va; b = vb; bin = vbin; in_valid = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    a = 18'($urandom); b = 18'($urandom); bin = 1'($urandom);
    check({tag, "_lat0"}, out_valid, 0);
    tick();
    check({tag, "_lat1"}, out_valid, 0);
    tick();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_bout"}, bout, eb);
`ifdef HC_SUB_OVF_EN
    check({tag, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) check({tag, "_ovf"}, 0, 1);
`endif
    tick();
    check({tag, "_drain"}, out_valid, 0);
  endtask

  initial begin
    int sent, got, n;
    logic xin, xout;
    logic [18:0] m, e;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
`ifdef HC_SUB_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;
    tick();

    run_one("v5m3",     18'h00005, 18'h00003, 1'b0, 18'h00002, 1'b0, 1'b0);
    run_one("v0m1",     18'h00000, 18'h00001, 1'b0, 18'h3FFFF, 1'b1, 1'b0);
    run_one("vmaxbin",  18'h3FFFF, 18'h3FFFF, 1'b1, 18'h3FFFF, 1'b1, 1'b0);
    run_one("ovf_pos",  18'h1FFFF, 18'h3FFFF, 1'b0, 18'h20000, 1'b1, 1'b1);
    run_one("ovf_neg",  18'h20000, 18'h00001, 1'b0, 18'h1FFFF, 1'b0, 1'b1);
    run_one("equal",    18'h12345, 18'h12345, 1'b0, 18'h00000, 1'b0, 1'b0);
    run_one("zero_bin", 18'h00000, 18'h00000, 1'b1, 18'h3FFFF, 1'b1, 1'b0);
    run_one("max_bin",  18'h3FFFF, 18'h00000, 1'b1, 18'h3FFFE, 1'b0, 1'b0);
    run_one("alt0",     18'h2AAAA, 18'h15555, 1'b0, 18'h15555, 1'b0, 1'b1);
    run_one("alt1",     18'h15555, 18'h2AAAA, 1'b1, 18'h2AAAA, 1'b1, 1'b1);

    // Backpressure: five beats against a stalled output
    sa[0] = 18'h00010; sb[0] = 18'h00001; sbin[0] = 1'b0; sexp[0] = {1'b0, 18'h0000F};
    sa[1] = 18'h00100; sb[1] = 18'h00200; sbin[1] = 1'b0; sexp[1] = {1'b1, 18'h3FF00};
    sa[2] = 18'h3FFFF; sb[2] = 18'h00000; sbin[2] = 1'b0; sexp[2] = {1'b0, 18'h3FFFF};
    sa[3] = 18'h00001; sb[3] = 18'h00001; sbin[3] = 1'b1; sexp[3] = {1'b1, 18'h3FFFF};
    sa[4] = 18'h2ABCD; sb[4] = 18'h01234; sbin[4] = 1'b1; sexp[4] = {1'b0, 18'h29998};
    out_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 4; c++) begin
      a = sa[sent]; b = sb[sent]; bin = sbin[sent]; in_valid = 1'b1;
      #1;
      check($sformatf("bp_in_ready_c%0d", c), in_ready, (c < 3) ? 1 : 0);
      if (in_ready) sent++;
      tick();
    end
    check("bp_accepted", sent, 3);
    check("bp_out_valid", out_valid, 1);
    check("bp_head", {bout, diff}, sexp[0]);
    tick();
    check("bp_hold", {bout, diff}, sexp[0]);
    check("bp_hold_ready", in_ready, 0);

    out_ready = 1'b1;
    got = 0;
    n = 0;
    while (got < 5 && n < 30) begin
      in_valid = (sent < 5);
      if (sent < 5) begin a = sa[sent]; b = sb[sent]; bin = sbin[sent]; end
      #1;
      xin  = in_valid & in_ready;
      xout = out_valid & out_ready;
      if (xout) begin
        check($sformatf("bp_out%0d", got), {bout, diff}, sexp[got]);
        got++;
      end
      tick();
      if (xin) sent++;
      n++;
    end
    in_valid = 1'b0;
    check("bp_count", got, 5);
    tick();
    check("bp_no_dup", out_valid, 0);

    // Reset with two beats in flight
    out_ready = 1'b0;
    a = 18'h00020; b = 18'h00003; bin = 1'b0; in_valid = 1'b1;
    tick();
    a = 18'h00030; b = 18'h00004;
    tick();
    in_valid = 1'b0;
    tick();
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_ready", in_ready, 1);
    check("rst_mid_diff", diff, 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post_rst_empty0", out_valid, 0);
    tick();
    check("post_rst_empty1", out_valid, 0);
    run_one("post_rst", 18'h00007, 18'h00009, 1'b0, 18'h3FFFE, 1'b1, 1'b0);

    // Random traffic against an arithmetic reference
    sent = 0; got = 0; n = 0;
    while ((sent < 3000 || got < sent) && n < 20000) begin
      in_valid  = (sent < 3000) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a   = 18'($urandom);
      b   = 18'($urandom);
      bin = 1'($urandom);
      #1;
      xin  = in_valid & in_ready;
      xout = out_valid & out_ready;
      if (xout) begin
        if (rq.size() == 0) begin
          check("rand_spurious", 1, 0);
        end else begin
          e = rq.pop_front();
          check($sformatf("rand_out%0d", got), {bout, diff}, e);
        end
        got++;
      end
      if (xin) begin
        m = {1'b0, a} - {1'b0, b} - {18'b0, bin};
        rq.push_back(m);
        sent++;
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("rand_sent", sent, 3000);
    check("rand_got", got, 3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
